// File: rtl/led_pio_out.sv
// led_pio_out: Avalon-MM slave output PIO driving board LEDs.
// Holds a DATA register, a per-bit BLINK mask and a blink PERIOD. A
// prescaler counter toggles a 2-state phase (ON=0 / OFF=1); during OFF the
// masked bits are forced off. readdata and out_port are both registered.
// Optional build macro: LED_PIO_INVERT_EN -- drives out_port active-low
// (bitwise inverse), while address 3 still reads back the logical value.
module led_pio_out #(
  parameter int                  WIDTH        = 10,
  parameter int                  PERIOD_W     = 24,
  parameter logic [WIDTH-1:0]    RESET_DATA   = {WIDTH{1'b0}},
  parameter logic [PERIOD_W-1:0] RESET_PERIOD = {PERIOD_W{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [1:0]          ADDR_DATA   = 2'd0;
  localparam logic [1:0]          ADDR_BLINK  = 2'd1;
  localparam logic [1:0]          ADDR_PERIOD = 2'd2;
  localparam logic [1:0]          ADDR_STATUS = 2'd3;
  localparam logic [PERIOD_W-1:0] CNT_ZERO    = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] CNT_ONE     = {{(PERIOD_W-1){1'b0}}, 1'b1};

  // Zero-extend an output-width value onto the 32-bit read bus.
  function automatic logic [31:0] zext_w(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Zero-extend a period-width value onto the 32-bit read bus.
  function automatic logic [31:0] zext_p(input logic [PERIOD_W-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[PERIOD_W-1:0] = v;
    return r;
  endfunction

  // Architectural state
  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_blink;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_phase;
  logic [WIDTH-1:0]    r_out_logic;   // logical (active-high) LED value
  logic [WIDTH-1:0]    r_out_port;    // physical LED drive
  logic [31:0]         r_readdata;

  // Write decode
  logic                w_wr;
  logic                w_wr_data;
  logic                w_wr_blink;
  logic                w_wr_period;
  logic                w_wr_toggle;

  // Next-state values
  logic [WIDTH-1:0]    w_data_next;
  logic [WIDTH-1:0]    w_blink_next;
  logic [PERIOD_W-1:0] w_period_next;
  logic [PERIOD_W-1:0] w_cnt_next;
  logic                w_phase_next;
  logic [WIDTH-1:0]    w_out_logic_next;
  logic [WIDTH-1:0]    w_out_port_next;
  logic [31:0]         w_rd_mux;

  // Decode the single write strobe into per-register write enables.
  always_comb begin
    w_wr        = chipselect & write;
    w_wr_data   = 1'b0;
    w_wr_blink  = 1'b0;
    w_wr_period = 1'b0;
    w_wr_toggle = 1'b0;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   w_wr_data   = 1'b1;
        ADDR_BLINK:  w_wr_blink  = 1'b1;
        ADDR_PERIOD: w_wr_period = 1'b1;
        ADDR_STATUS: w_wr_toggle = 1'b1;
        default: begin
          w_wr_data   = 1'b0;
          w_wr_blink  = 1'b0;
          w_wr_period = 1'b0;
          w_wr_toggle = 1'b0;
        end
      endcase
    end else begin
      w_wr_data   = 1'b0;
      w_wr_blink  = 1'b0;
      w_wr_period = 1'b0;
      w_wr_toggle = 1'b0;
    end
  end

  // Next DATA / BLINK / PERIOD from software writes; toggle XORs into DATA.
  always_comb begin
    w_data_next   = r_data;
    w_blink_next  = r_blink;
    w_period_next = r_period;
    if (w_wr_data) begin
      w_data_next = writedata[WIDTH-1:0];
    end else if (w_wr_toggle) begin
      w_data_next = r_data ^ writedata[WIDTH-1:0];
    end else begin
      w_data_next = r_data;
    end
    if (w_wr_blink) begin
      w_blink_next = writedata[WIDTH-1:0];
    end else begin
      w_blink_next = r_blink;
    end
    if (w_wr_period) begin
      w_period_next = writedata[PERIOD_W-1:0];
    end else begin
      w_period_next = r_period;
    end
  end

  // Blink prescaler: a PERIOD write restarts the ON phase and beats a
  // coincident terminal count; PERIOD==0 parks the timer in ON.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_phase_next = r_phase;
    if (w_wr_period) begin
      w_cnt_next   = writedata[PERIOD_W-1:0];
      w_phase_next = 1'b0;
    end else if (r_period == CNT_ZERO) begin
      w_cnt_next   = CNT_ZERO;
      w_phase_next = 1'b0;
    end else if (r_cnt == CNT_ZERO) begin
      w_cnt_next   = r_period;
      w_phase_next = ~r_phase;
    end else begin
      w_cnt_next   = r_cnt - CNT_ONE;
      w_phase_next = r_phase;
    end
  end

  // LED value built from the post-edge registers and phase, then polarity.
  always_comb begin
    w_out_logic_next = w_data_next & ~(w_blink_next & {WIDTH{w_phase_next}});
`ifdef LED_PIO_INVERT_EN
    w_out_port_next  = ~w_out_logic_next;
`else
    w_out_port_next  = w_out_logic_next;
`endif
  end

  // Read mux over current register contents; status reads the logical LEDs.
  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      ADDR_DATA:   w_rd_mux = zext_w(r_data);
      ADDR_BLINK:  w_rd_mux = zext_w(r_blink);
      ADDR_PERIOD: w_rd_mux = zext_p(r_period);
      ADDR_STATUS: w_rd_mux = zext_w(r_out_logic);
      default:     w_rd_mux = 32'd0;
    endcase
  end

  // Register file, blink timer, LED drive and read data, with sync reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= RESET_DATA;
      r_blink     <= {WIDTH{1'b0}};
      r_period    <= RESET_PERIOD;
      r_cnt       <= RESET_PERIOD;
      r_phase     <= 1'b0;
      r_out_logic <= RESET_DATA;
`ifdef LED_PIO_INVERT_EN
      r_out_port  <= ~RESET_DATA;
`else
      r_out_port  <= RESET_DATA;
`endif
      r_readdata  <= 32'd0;
    end else begin
      r_data      <= w_data_next;
      r_blink     <= w_blink_next;
      r_period    <= w_period_next;
      r_cnt       <= w_cnt_next;
      r_phase     <= w_phase_next;
      r_out_logic <= w_out_logic_next;
      r_out_port  <= w_out_port_next;
      r_readdata  <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out_port;

endmodule

// File: tb/tb_led_pio_out.sv
// Self-checking bench for led_pio_out. The reference model tracks the
// software-visible registers and derives the blink phase arithmetically
// from the number of clock edges since the last PERIOD load.
module tb_led_pio_out;

  localparam int W  = 10;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            edge_n = 0;
  int            m_t0   = 0;
  logic [W-1:0]  m_data  = '0;
  logic [W-1:0]  m_blink = '0;
  logic [PW-1:0] m_period = '0;
  logic [W-1:0]  m_out   = '0;
  logic          m_phase = 1'b0;
  logic [W-1:0]  exp_out = '0;
  logic [31:0]   exp_rd  = '0;

  led_pio_out dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pol(input logic [W-1:0] v);
`ifdef LED_PIO_INVERT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // One bus cycle: drive on negedge, advance model at posedge, settle 1.
  task automatic step(input logic rs, input logic cs, input logic we,
                      input logic [1:0] a, input logic [31:0] wd);
    int k;
    int p;
    @(negedge clk);
    reset = rs; chipselect = cs; write = we; address = a; writedata = wd;
    @(posedge clk);
    edge_n++;
    if (rs) begin
      m_data = '0; m_blink = '0; m_period = '0; m_t0 = edge_n; exp_rd = 32'd0;
    end else begin
      case (a)
        2'd0:    exp_rd = {22'd0, m_data};
        2'd1:    exp_rd = {22'd0, m_blink};
        2'd2:    exp_rd = {8'd0, m_period};
        default: exp_rd = {22'd0, m_out};
      endcase
      if (cs && we) begin
        case (a)
          2'd0:    m_data = wd[W-1:0];
          2'd1:    m_blink = wd[W-1:0];
          2'd2:    begin m_period = wd[PW-1:0]; m_t0 = edge_n; end
          default: m_data = m_data ^ wd[W-1:0];
        endcase
      end
    end
    p = int'(m_period);
    k = edge_n - m_t0;
    m_phase = (p == 0) ? 1'b0 : (((k / (p + 1)) % 2) == 1);
    m_out   = m_data & ~(m_blink & {W{m_phase}});
    exp_out = pol(m_out);
    #1;
  endtask

  task automatic idle(input logic [1:0] a);
    step(1'b0, 1'b0, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    step(1'b0, 1'b1, 1'b1, a, wd);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    n_tests++;
    if (out_port !== pol(10'h000)) begin
      n_fail++; $display("FAIL reset_out: got %h expected %h", out_port, pol(10'h000));
    end
    n_tests++;
    if (readdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rd: got %h expected %h", readdata, 32'd0);
    end
    for (int a = 0; a < 4; a++) begin
      idle(2'(a));
      idle(2'(a));
      n_tests++;
      if (readdata !== 32'd0 || readdata !== exp_rd) begin
        n_fail++; $display("FAIL reset_read_addr%0d: got %h expected %h", a, readdata, 32'd0);
      end
    end
  endtask

  task automatic test_write_readback;
    wr(2'd0, 32'hFFFF_F2A5);
    n_tests++;
    if (out_port !== pol(10'h2A5) || out_port !== exp_out) begin
      n_fail++; $display("FAIL wr_data_out: got %h expected %h", out_port, pol(10'h2A5));
    end
    n_tests++;
    if (readdata !== 32'd0 || readdata !== exp_rd) begin
      n_fail++; $display("FAIL same_cycle_read: got %h expected %h", readdata, 32'd0);
    end
    idle(2'd0);
    n_tests++;
    if (readdata !== 32'h0000_02A5 || readdata !== exp_rd) begin
      n_fail++; $display("FAIL readback_data: got %h expected %h", readdata, 32'h0000_02A5);
    end
  endtask

  task automatic test_toggle;
    wr(2'd3, 32'h0000_000F);
    n_tests++;
    if (out_port !== pol(10'h2AA) || out_port !== exp_out) begin
      n_fail++; $display("FAIL toggle_out: got %h expected %h", out_port, pol(10'h2AA));
    end
    idle(2'd3);
    n_tests++;
    if (readdata !== 32'h0000_02AA || readdata !== exp_rd) begin
      n_fail++; $display("FAIL toggle_status_read: got %h expected %h", readdata, 32'h0000_02AA);
    end
    step(1'b0, 1'b0, 1'b1, 2'd3, 32'h0000_03FF);
    idle(2'd0);
    n_tests++;
    if (out_port !== pol(10'h2AA) || readdata !== 32'h0000_02AA) begin
      n_fail++; $display("FAIL no_cs_write: got out %h rd %h expected out %h rd %h",
                         out_port, readdata, pol(10'h2AA), 32'h0000_02AA);
    end
  endtask

  task automatic test_blink;
    int changes;
    logic [W-1:0] prev;
    int guard;
    wr(2'd0, 32'h0000_03FF);
    wr(2'd1, 32'h0000_0003);
    wr(2'd2, 32'h0000_0004);
    prev = out_port;
    changes = 0;
    for (int i = 1; i <= 30; i++) begin
      idle(2'd3);
      n_tests++;
      if (out_port !== exp_out) begin
        n_fail++; $display("FAIL blink_cycle%0d: got %h expected %h", i, out_port, exp_out);
      end
      if (i == 5) begin
        n_tests++;
        if (out_port !== pol(10'h3FC)) begin
          n_fail++; $display("FAIL blink_first_off: got %h expected %h", out_port, pol(10'h3FC));
        end
      end
      if (out_port !== prev) changes++;
      prev = out_port;
    end
    n_tests++;
    if (changes != 6) begin
      n_fail++; $display("FAIL blink_transitions: got %0d expected %0d", changes, 6);
    end
    guard = 0;
    while (m_phase !== 1'b1 && guard < 20) begin
      idle(2'd0);
      guard++;
    end
    n_tests++;
    if (guard >= 20 || out_port !== pol(10'h3FC)) begin
      n_fail++; $display("FAIL blink_reach_off: got %h expected %h", out_port, pol(10'h3FC));
    end
    wr(2'd2, 32'h0000_0000);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (out_port !== pol(10'h3FF) || out_port !== exp_out) begin
        n_fail++; $display("FAIL period0_hold%0d: got %h expected %h", i, out_port, pol(10'h3FF));
      end
      idle(2'd0);
    end
  endtask

  task automatic test_collision;
    wr(2'd2, 32'h0000_0004);
    for (int i = 0; i < 4; i++) idle(2'd0);
    wr(2'd2, 32'h0000_0002);
    n_tests++;
    if (out_port !== pol(10'h3FF) || out_port !== exp_out) begin
      n_fail++; $display("FAIL collision_no_toggle: got %h expected %h", out_port, pol(10'h3FF));
    end
    idle(2'd0);
    idle(2'd0);
    n_tests++;
    if (out_port !== pol(10'h3FF)) begin
      n_fail++; $display("FAIL collision_still_on: got %h expected %h", out_port, pol(10'h3FF));
    end
    idle(2'd0);
    n_tests++;
    if (out_port !== pol(10'h3FC) || out_port !== exp_out) begin
      n_fail++; $display("FAIL collision_toggle3: got %h expected %h", out_port, pol(10'h3FC));
    end
    step(1'b1, 1'b0, 1'b0, 2'd1, 32'd0);
    n_tests++;
    if (out_port !== pol(10'h000)) begin
      n_fail++; $display("FAIL reset_mid_off: got %h expected %h", out_port, pol(10'h000));
    end
    idle(2'd1);
    n_tests++;
    if (readdata !== 32'd0 || out_port !== pol(10'h000)) begin
      n_fail++; $display("FAIL reset_blink_clear: got rd %h out %h expected rd %h out %h",
                         readdata, out_port, 32'd0, pol(10'h000));
    end
  endtask

  task automatic test_random;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        rs;
    for (int i = 0; i < 500; i++) begin
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (a == 2'd2) wd = (wd & 32'hFF00_0000) | 32'($urandom_range(0, 6));
      rs = ($urandom_range(0, 63) == 0);
      step(rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
      n_tests++;
      if (out_port !== exp_out || readdata !== exp_rd) begin
        n_fail++; $display("FAIL random%0d: got out %h rd %h expected out %h rd %h",
                           i, out_port, readdata, exp_out, exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_toggle();
    test_blink();
    test_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
